// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_pkg
// Description : Shared constants for the quadrature-to-joystick decoder:
//               the four quadrature phases and the step classification.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_pkg;

  // Quadrature phases in right-hand rotation order: 00 -> 10 -> 11 -> 01 -> 00
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_INC     = 2'd1,
    STEP_DEC     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_class_e;

  // Classify the move from one accepted phase to the next.
  function automatic step_class_e classify(input logic [1:0] prev, input logic [1:0] cur);
    step_class_e c;
    c = STEP_NONE;
    case ({prev, cur})
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: c = STEP_INC;
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: c = STEP_DEC;
      {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: c = STEP_ILLEGAL;
      default:                                                        c = STEP_NONE;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_filter.sv
`default_nettype none
// ============================================================================
// Module      : quad_filter
// Description : Synchronizer chain plus whole-vector glitch filter for the
//               2-bit quadrature pair. Emits a pulse when a new value is
//               accepted and a pulse whenever the input window is settled.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] quad,
  output logic [1:0] filt,
  output logic       upd,
  output logic       settle
);
  import quad_pkg::*;

  localparam int                CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q [SYNC_STAGES];
  logic [1:0]       sync_d [SYNC_STAGES];
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic             upd_q, upd_d;
  logic             settle_q, settle_d;
  logic [1:0]       sync_now;
  logic             changing, mismatch, load;

  // Shift the raw pair through the synchronizer chain.
  always_comb begin
    sync_d[0] = quad;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Qualify the synchronized vector; "changing" looks one stage ahead so a
  // new value restarts the count on the same edge it reaches the output.
  always_comb begin
    sync_now = sync_q[SYNC_STAGES-1];
    changing = (sync_q[SYNC_STAGES-2] != sync_now);
    mismatch = (sync_now != filt_q);
    load     = mismatch && !changing && (cnt_q == CNT_MAX);
    filt_d   = load ? sync_now : filt_q;
    cnt_d    = (mismatch && !changing && !load) ? cnt_q + CNT_W'(1) : '0;
    stab_d   = changing ? '0 : ((stab_q == CNT_MAX) ? stab_q : stab_q + CNT_W'(1));
    upd_d    = load;
    settle_d = !changing && (stab_q == CNT_MAX);
  end

  // Filter state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= PH_00;
      end
      filt_q   <= PH_00;
      cnt_q    <= '0;
      stab_q   <= '0;
      upd_q    <= 1'b0;
      settle_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      stab_q   <= stab_d;
      upd_q    <= upd_d;
      settle_q <= settle_d;
    end
  end

  assign filt   = filt_q;
  assign upd    = upd_q;
  assign settle = settle_q;

endmodule
`default_nettype wire

// File: rtl/quad2joy.sv
`default_nettype none
// ============================================================================
// Module      : quad2joy
// Description : Quadrature decoder producing a wrapping position count, step
//               and error pulses, and timed left/right joystick levels.
// Revision    : 1.0 - initial release
// ============================================================================
module quad2joy #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILTER_LEN  = 4,
  parameter int          POS_W       = 8,
  parameter int unsigned TIMEOUT     = 32'd1000000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       quad,
  output logic [POS_W-1:0] position,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             left,
  output logic             right
);
  import quad_pkg::*;

  logic [1:0]       filt;
  logic             upd, settle;

  logic [1:0]       prev_q, prev_d;
  logic             first_q, first_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic [31:0]      idle_q, idle_d;
  logic             valid_step;
  step_class_e      cls;

  quad_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .quad    (quad),
    .filt    (filt),
    .upd     (upd),
    .settle  (settle)
  );

  // Decode accepted phases into steps/errors and run the idle timeout.
  // The first settled window after reset (whether or not it changed the
  // filtered value) only seeds the previous phase.
  always_comb begin
    prev_d     = prev_q;
    first_d    = first_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    idle_d     = idle_q;
    valid_step = 1'b0;
    cls        = classify(prev_q, filt);

    if (settle && first_q) begin
      prev_d  = filt;
      first_d = 1'b0;
    end else if (upd && !first_q) begin
      case (cls)
        STEP_INC: begin
          step_d     = 1'b1;
          dir_d      = 1'b1;
          pos_d      = pos_q + POS_W'(1);
          right_d    = 1'b1;
          left_d     = 1'b0;
          valid_step = 1'b1;
        end
        STEP_DEC: begin
          step_d     = 1'b1;
          dir_d      = 1'b0;
          pos_d      = pos_q - POS_W'(1);
          left_d     = 1'b1;
          right_d    = 1'b0;
          valid_step = 1'b1;
        end
        STEP_ILLEGAL: err_d = 1'b1;
        default:      ;
      endcase
      prev_d = filt;
    end

    if (valid_step) begin
      idle_d = TIMEOUT;
    end else if (idle_q != 32'd0) begin
      idle_d = idle_q - 32'd1;
      if (idle_q == 32'd1) begin
        left_d  = 1'b0;
        right_d = 1'b0;
      end
    end
  end

  // Decoder and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_q  <= PH_00;
      first_q <= 1'b1;
      pos_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      idle_q  <= 32'd0;
    end else begin
      prev_q  <= prev_d;
      first_q <= first_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      left_q  <= left_d;
      right_q <= right_d;
      idle_q  <= idle_d;
    end
  end

  assign position = pos_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;
  assign left     = left_q;
  assign right    = right_q;

endmodule
`default_nettype wire

// File: tb/tb_quad2joy.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad2joy
// Description : Self-checking bench for quad2joy: sample-history reference
//               model compared every cycle, directed scenarios with literal
//               expectations, then randomized quadrature traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad2joy;

  localparam int          S  = 2;
  localparam int          F  = 4;
  localparam int          PW = 8;
  localparam int unsigned TO = 16;
  localparam int          HL = S + F - 1;

  logic          CLK     = 1'b0;
  logic          RESET_N = 1'b0;
  logic [1:0]    quad    = 2'b00;
  logic [PW-1:0] position;
  logic          step, dir, err, left, right;

  quad2joy #(
    .SYNC_STAGES (S),
    .FILTER_LEN  (F),
    .POS_W       (PW),
    .TIMEOUT     (TO)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .quad     (quad),
    .position (position),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .left     (left),
    .right    (right)
  );

  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Reference model: keeps the raw samples; a value is accepted once the
  // window of F+1 samples ending S-1 edges back is uniform, and acted on the
  // following edge. Direction comes from distance around the phase ring.
  // --------------------------------------------------------------------------
  logic [1:0]    hist [HL];
  int            m_edges  = 0;
  logic [1:0]    m_filt   = 2'b00;
  logic [1:0]    m_prev   = 2'b00;
  bit            m_first  = 1'b1;
  bit            p_settle = 1'b0;
  bit            p_load   = 1'b0;
  logic [1:0]    p_val    = 2'b00;
  logic [PW-1:0] m_pos    = '0;
  bit            m_step   = 1'b0;
  bit            m_dir    = 1'b0;
  bit            m_err    = 1'b0;
  bit            m_left   = 1'b0;
  bit            m_right  = 1'b0;
  int unsigned   m_idle   = 0;

  function automatic int ring_idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int j = 0; j < HL; j++) hist[j] = 2'b00;
      m_edges = 0; m_filt = 2'b00; m_prev = 2'b00; m_first = 1'b1;
      p_settle = 1'b0; p_load = 1'b0; p_val = 2'b00;
      m_pos = '0; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0;
      m_left = 1'b0; m_right = 1'b0; m_idle = 0;
    end else begin : model_edge
      int         d;
      bit         all_eq;
      bit         vstep;
      logic [1:0] v;
      m_step = 1'b0;
      m_err  = 1'b0;
      vstep  = 1'b0;
      if (p_settle && m_first) begin
        m_prev  = p_val;
        m_first = 1'b0;
      end else if (p_load && !m_first) begin
        d = (ring_idx(p_val) - ring_idx(m_prev) + 4) % 4;
        if (d == 1) begin
          m_step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 1'b1;
          m_right = 1'b1; m_left = 1'b0; vstep = 1'b1;
        end else if (d == 3) begin
          m_step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 1'b1;
          m_left = 1'b1; m_right = 1'b0; vstep = 1'b1;
        end else if (d == 2) begin
          m_err = 1'b1;
        end
        m_prev = p_val;
      end
      if (vstep) begin
        m_idle = TO;
      end else if (m_idle > 0) begin
        m_idle = m_idle - 1;
        if (m_idle == 0) begin
          m_left  = 1'b0;
          m_right = 1'b0;
        end
      end
      v      = hist[S-2];
      all_eq = 1'b1;
      for (int j = S - 2; j < HL; j++) if (hist[j] != v) all_eq = 1'b0;
      p_settle = all_eq && (m_edges >= F - 1);
      p_load   = p_settle && (v != m_filt);
      p_val    = v;
      if (p_load) m_filt = v;
      for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = quad;
      m_edges = m_edges + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Checking and stimulus (single process).
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int n_step   = 0;
  int n_err    = 0;
  int n_right  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge CLK);
    checks++;
    if ({position, step, dir, err, left, right} !==
        {m_pos, m_step, m_dir, m_err, m_left, m_right}) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t dut pos=%h step=%b dir=%b err=%b l=%b r=%b model pos=%h step=%b dir=%b err=%b l=%b r=%b",
               $time, position, step, dir, err, left, right,
               m_pos, m_step, m_dir, m_err, m_left, m_right);
    end
    checks++;
    if (step === 1'b1 && err === 1'b1) begin
      failures++;
      $display("FAIL step_err_excl t=%0t actual=11 expected=not both", $time);
    end
    if (step === 1'b1) n_step++;
    if (err === 1'b1) n_err++;
    if (right === 1'b1) n_right++;
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    quad = v;
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input int n);
    #2 RESET_N = 1'b0;
    repeat (n) tick();
    #2 RESET_N = 1'b1;
    tick();
  endtask

  logic [1:0] ring [4];
  int         bs, be, br, p0, lr0, cur, r, len;

  initial begin
    ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;

    // Reset state
    repeat (3) tick();
    chk("reset_position", int'(position), 0);
    chk("reset_flags", int'({step, dir, err, left, right}), 0);
    #2 RESET_N = 1'b1;
    tick();
    hold(2'b00, 20);

    // Full right rotation
    bs = n_step; be = n_err;
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    chk("rot_steps", n_step - bs, 4);
    chk("rot_errs", n_err - be, 0);
    chk("rot_pos", int'(position), 4);
    chk("rot_dir", int'(dir), 1);
    chk("rot_right", int'(right), 1);
    chk("rot_left", int'(left), 0);

    // Single left step from zero with exact latency
    pulse_reset(2);
    hold(2'b00, 20);
    quad = 2'b01;
    repeat (6) tick();
    chk("lat_no_step_yet", int'(step), 0);
    chk("lat_pos_before", int'(position), 0);
    tick();
    chk("lat_step", int'(step), 1);
    chk("wrap_pos", int'(position), 8'hFF);
    chk("wrap_dir", int'(dir), 0);
    chk("wrap_left", int'(left), 1);
    chk("wrap_right", int'(right), 0);
    hold(2'b01, 10);

    // 3-cycle glitch is rejected
    hold(2'b00, 12);
    bs = n_step; be = n_err; p0 = int'(position);
    hold(2'b10, 3); hold(2'b00, 15);
    chk("glitch_steps", n_step - bs, 0);
    chk("glitch_errs", n_err - be, 0);
    chk("glitch_pos", int'(position), p0);

    // Illegal jump, then a valid step
    bs = n_step; be = n_err; p0 = int'(position); lr0 = int'({left, right});
    hold(2'b11, 12);
    chk("illegal_errs", n_err - be, 1);
    chk("illegal_steps", n_step - bs, 0);
    chk("illegal_pos", int'(position), p0);
    chk("illegal_lr", int'({left, right}), lr0);
    bs = n_step;
    hold(2'b01, 12);
    chk("after_illegal_steps", n_step - bs, 1);
    chk("after_illegal_pos", int'(position), (p0 + 1) % 256);

    // Idle timeout releases right after exactly TO cycles
    hold(2'b01, 30);
    chk("idle_expired", int'(right), 0);
    p0 = int'(position);
    br = n_right;
    hold(2'b00, 40);
    chk("timeout_right_cycles", n_right - br, 16);
    chk("timeout_pos_kept", int'(position), (p0 + 1) % 256);

    // Reset mid-transition, release with 11 held
    quad = 2'b11;
    repeat (2) tick();
    pulse_reset(2);
    chk("midrst_outputs", int'({position, step, dir, err, left, right}), 0);
    bs = n_step; be = n_err;
    hold(2'b11, 20);
    chk("midrst_steps", n_step - bs, 0);
    chk("midrst_errs", n_err - be, 0);

    // Randomized traffic
    cur = 2;
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)      cur = (cur + 1) % 4;
      else if (r <= 6) cur = (cur + 3) % 4;
      else if (r == 7) cur = (cur + 2) % 4;
      len = int'($urandom_range(1, 14));
      hold(ring[cur], len);
      if ($urandom_range(0, 49) == 0) pulse_reset(int'($urandom_range(1, 3)));
    end
    hold(ring[cur], 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
